// File: rtl/ls_req_arbiter.sv
// Two-master request arbiter in front of load_store_top: round-robin grant with lock-until-accept,
// and an order FIFO that routes in-order responses back to the issuing master. Define LS_ARB_FIXED_PRIO_EN for fixed m0 priority.
module ls_req_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               m0_req_valid,
    output logic                               m0_req_ready,
    input  logic                               m0_req_wr,
    input  logic [ADDR_WIDTH-1:0]              m0_req_addr,
    input  logic [DATA_WIDTH-1:0]              m0_req_wdata,
    output logic                               m0_resp_valid,
    input  logic                               m0_resp_ready,
    output logic [DATA_WIDTH-1:0]              m0_resp_rdata,
    output logic                               m0_resp_error,
    input  logic                               m1_req_valid,
    output logic                               m1_req_ready,
    input  logic                               m1_req_wr,
    input  logic [ADDR_WIDTH-1:0]              m1_req_addr,
    input  logic [DATA_WIDTH-1:0]              m1_req_wdata,
    output logic                               m1_resp_valid,
    input  logic                               m1_resp_ready,
    output logic [DATA_WIDTH-1:0]              m1_resp_rdata,
    output logic                               m1_resp_error,
    output logic                               req_valid,
    input  logic                               req_ready,
    output logic                               req_wr,
    output logic [ADDR_WIDTH-1:0]              req_addr,
    output logic [DATA_WIDTH-1:0]              req_wdata,
    input  logic                               resp_valid,
    output logic                               resp_ready,
    input  logic [DATA_WIDTH-1:0]              resp_rdata,
    input  logic                               resp_error,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               spurious_resp
);
    // All ports use valid/ready: a transfer happens in the cycle both are high; a presented
    // request (valid high) keeps its payload and its grant until it is accepted.
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    logic                       grant;
    logic                       lock;
    logic                       lock_id;
    logic [MAX_OUTSTANDING-1:0] id_fifo;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              count;
    logic                       full;
    logic                       empty;
    logic                       head;
    logic                       push;
    logic                       pop;

    assign full  = (count == CW'(MAX_OUTSTANDING));
    assign empty = (count == '0);
    assign head  = id_fifo[rd_ptr];

`ifdef LS_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = 1'b0;
        if (lock)
            grant = lock_id;
        else if (!m0_req_valid && m1_req_valid)
            grant = 1'b1;
    end
`else
    logic rr_ptr;

    always_comb begin
        grant = 1'b0;
        if (lock)
            grant = lock_id;
        else if (m0_req_valid && m1_req_valid)
            grant = rr_ptr;
        else if (m1_req_valid)
            grant = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= 1'b0;
        else if (push)
            rr_ptr <= ~grant;
    end
`endif

    assign req_valid    = (grant ? m1_req_valid : m0_req_valid) && !full;
    assign req_wr       = grant ? m1_req_wr    : m0_req_wr;
    assign req_addr     = grant ? m1_req_addr  : m0_req_addr;
    assign req_wdata    = grant ? m1_req_wdata : m0_req_wdata;
    assign m0_req_ready = !grant && req_ready && !full;
    assign m1_req_ready =  grant && req_ready && !full;
    assign push         = req_valid && req_ready;

    // With no outstanding request the response is swallowed and flagged.
    assign resp_ready    = empty ? 1'b1 : (head ? m1_resp_ready : m0_resp_ready);
    assign m0_resp_valid = resp_valid && !empty && !head;
    assign m1_resp_valid = resp_valid && !empty &&  head;
    assign m0_resp_rdata = resp_rdata;
    assign m1_resp_rdata = resp_rdata;
    assign m0_resp_error = resp_error;
    assign m1_resp_error = resp_error;
    assign pop           = resp_valid && resp_ready && !empty;
    assign outstanding   = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock          <= 1'b0;
            lock_id       <= 1'b0;
            id_fifo       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            spurious_resp <= 1'b0;
        end else begin
            if (push) begin
                lock            <= 1'b0;
                id_fifo[wr_ptr] <= grant;
                wr_ptr          <= wr_ptr + 1'b1;
            end else if (req_valid) begin
                lock    <= 1'b1;
                lock_id <= grant;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // Full is judged on the registered count, so a same-cycle pop never admits a push.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (resp_valid && empty)
                spurious_resp <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ls_req_arbiter.sv
// Directed bench for ls_req_arbiter: a per-cycle vector table for grant/FIFO behaviour,
// then hand sequences for data routing, response back-pressure, mid-operation reset and spurious responses.
module tb_ls_req_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req_valid = 0, m0_req_wr = 0, m0_resp_ready = 0;
    logic        m1_req_valid = 0, m1_req_wr = 0, m1_resp_ready = 0;
    logic [31:0] m0_req_addr = 0, m0_req_wdata = 0, m1_req_addr = 0, m1_req_wdata = 0;
    logic        m0_req_ready, m0_resp_valid, m0_resp_error;
    logic        m1_req_ready, m1_resp_valid, m1_resp_error;
    logic [31:0] m0_resp_rdata, m1_resp_rdata;
    logic        req_valid, req_wr, resp_ready, spurious_resp;
    logic        req_ready = 0, resp_valid = 0, resp_error = 0;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] resp_rdata = 0;
    logic [2:0]  outstanding;

    int checks = 0;
    int errors = 0;
    int m0_resp_cnt = 0;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;

    ls_req_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_wr(m0_req_wr),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
        .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
        .m0_resp_rdata(m0_resp_rdata), .m0_resp_error(m0_resp_error),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_wr(m1_req_wr),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
        .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
        .m1_resp_rdata(m1_resp_rdata), .m1_resp_error(m1_resp_error),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error),
        .outstanding(outstanding), .spurious_resp(spurious_resp)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && m0_resp_valid && m0_resp_ready)
            m0_resp_cnt++;

    // Bits: m0v m1v rq rsv m0r m1r | e_rv e_m0rdy e_m1rdy e_gnt e_rsr e_m0s e_m1s, then e_out.
    typedef struct packed {
        logic m0v, m1v, rq, rsv, m0r, m1r;
        logic e_rv, e_m0r, e_m1r, e_gnt, e_rsr, e_m0s, e_m1s;
        logic [2:0] e_out;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [12:0] b, input logic [2:0] o);
        return {b, o};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        m0_req_valid = 0; m1_req_valid = 0; req_ready = 0;
        resp_valid = 0; resp_error = 0; m0_resp_ready = 0; m1_resp_ready = 0;
    endtask

    task automatic set_in(input logic m0v, m1v, rq, rsv, m0r, m1r);
        m0_req_valid = m0v; m1_req_valid = m1v; req_ready = rq;
        resp_valid = rsv; m0_resp_ready = m0r; m1_resp_ready = m1r;
    endtask

    initial begin
        vecs.push_back(mk(13'b111000_1100100, 3'd0));  // rr: m0
        vecs.push_back(mk(13'b111000_1011000, 3'd1));  // rr: m1
        vecs.push_back(mk(13'b111000_1100000, 3'd2));
        vecs.push_back(mk(13'b111000_1011000, 3'd3));
        vecs.push_back(mk(13'b111100_0000010, 3'd4));  // full, m0 holds response
        vecs.push_back(mk(13'b111110_0000110, 3'd4));  // pop does not free this cycle
        vecs.push_back(mk(13'b111101_1100101, 3'd3));  // push + pop
        vecs.push_back(mk(13'b000110_0000110, 3'd3));
        vecs.push_back(mk(13'b000110_0000001, 3'd2));  // head m1 not ready
        vecs.push_back(mk(13'b000101_0000101, 3'd2));
        vecs.push_back(mk(13'b000110_0000110, 3'd1));
        vecs.push_back(mk(13'b100000_1000100, 3'd0));  // m0 stalled -> lock
        vecs.push_back(mk(13'b110000_1000100, 3'd0));  // m1 cannot pre-empt
        vecs.push_back(mk(13'b110000_1000100, 3'd0));
        vecs.push_back(mk(13'b111000_1100100, 3'd0));  // m0 accepted first
        vecs.push_back(mk(13'b111000_1011000, 3'd1));
        vecs.push_back(mk(13'b000111_0000110, 3'd2));
        vecs.push_back(mk(13'b000111_0000101, 3'd1));
        vecs.push_back(mk(13'b000000_0000100, 3'd0));
        vecs.push_back(mk(13'b011000_1011100, 3'd0));  // lone m1
        vecs.push_back(mk(13'b000101_0000101, 3'd1));
        vecs.push_back(mk(13'b010000_1001100, 3'd0));  // m1 lock
        vecs.push_back(mk(13'b111000_1011100, 3'd0));  // lock beats rr_ptr=0
        vecs.push_back(mk(13'b000101_0000101, 3'd1));

        // reset state
        idle();
        #2;
        check("rst_req_valid", req_valid, 0);
        check("rst_m0_req_ready", m0_req_ready, 0);
        check("rst_m1_req_ready", m1_req_ready, 0);
        check("rst_resp_ready", resp_ready, 1);
        check("rst_m0_resp_valid", m0_resp_valid, 0);
        check("rst_m1_resp_valid", m1_resp_valid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_spurious", spurious_resp, 0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("post_rst_resp_ready", resp_ready, 1);
        check("post_rst_outstanding", outstanding, 0);

        // vector table
        m0_req_addr = A0; m0_req_wdata = A0 ^ 32'hFFFF;
        m1_req_addr = A1; m1_req_wdata = A1 ^ 32'hFFFF;
        foreach (vecs[i]) begin
            cyc();
            set_in(vecs[i].m0v, vecs[i].m1v, vecs[i].rq, vecs[i].rsv, vecs[i].m0r, vecs[i].m1r);
            resp_rdata = 32'hA500_0000 | 32'(i);
            #1;
            check($sformatf("v%0d_req_valid", i), req_valid, vecs[i].e_rv);
            check($sformatf("v%0d_m0_req_ready", i), m0_req_ready, vecs[i].e_m0r);
            check($sformatf("v%0d_m1_req_ready", i), m1_req_ready, vecs[i].e_m1r);
            check($sformatf("v%0d_resp_ready", i), resp_ready, vecs[i].e_rsr);
            check($sformatf("v%0d_m0_resp_valid", i), m0_resp_valid, vecs[i].e_m0s);
            check($sformatf("v%0d_m1_resp_valid", i), m1_resp_valid, vecs[i].e_m1s);
            check($sformatf("v%0d_outstanding", i), outstanding, vecs[i].e_out);
            if (vecs[i].e_rv) begin
                check($sformatf("v%0d_req_addr", i), req_addr, vecs[i].e_gnt ? A1 : A0);
                check($sformatf("v%0d_req_wdata", i), req_wdata, (vecs[i].e_gnt ? A1 : A0) ^ 32'hFFFF);
            end
            if (vecs[i].e_m0s) check($sformatf("v%0d_m0_rdata", i), m0_resp_rdata, 32'hA500_0000 | 32'(i));
            if (vecs[i].e_m1s) check($sformatf("v%0d_m1_rdata", i), m1_resp_rdata, 32'hA500_0000 | 32'(i));
        end

        // store then load to the same address
        cyc();
        idle();
        m0_resp_cnt = 0;
        m0_req_valid = 1; m0_req_wr = 1; m0_req_addr = 32'h100; m0_req_wdata = 32'hDEAD_BEEF; req_ready = 1;
        #1;
        check("st_req_valid", req_valid, 1);
        check("st_req_wr", req_wr, 1);
        check("st_req_addr", req_addr, 32'h100);
        check("st_req_wdata", req_wdata, 32'hDEAD_BEEF);
        check("st_m0_req_ready", m0_req_ready, 1);
        cyc();
        m0_req_valid = 0;
        m1_req_valid = 1; m1_req_wr = 0; m1_req_addr = 32'h100;
        #1;
        check("ld_req_wr", req_wr, 0);
        check("ld_req_addr", req_addr, 32'h100);
        check("ld_m1_req_ready", m1_req_ready, 1);
        cyc();
        m1_req_valid = 0; req_ready = 0;
        resp_valid = 1; resp_rdata = 32'h0; resp_error = 0; m0_resp_ready = 1; m1_resp_ready = 1;
        #1;
        check("st_resp_m0_valid", m0_resp_valid, 1);
        check("st_resp_m1_valid", m1_resp_valid, 0);
        check("st_resp_error", m0_resp_error, 0);
        cyc();
        resp_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld_resp_m1_valid", m1_resp_valid, 1);
        check("ld_resp_m0_valid", m0_resp_valid, 0);
        check("ld_resp_rdata", m1_resp_rdata, 32'hDEAD_BEEF);
        check("ld_resp_error", m1_resp_error, 0);
        cyc();
        idle();
        #1;
        check("st_ld_outstanding", outstanding, 0);
        check("st_m0_resp_count", m0_resp_cnt, 1);

        // m1 holds its response; m0 must wait behind it
        cyc();
        m1_req_valid = 1; m1_req_addr = 32'h200; m1_req_wr = 0; req_ready = 1;
        #1;
        check("bp_m1_req_ready", m1_req_ready, 1);
        cyc();
        m1_req_valid = 0;
        m0_req_valid = 1; m0_req_addr = 32'h204; m0_req_wr = 0;
        #1;
        check("bp_m0_req_ready", m0_req_ready, 1);
        check("bp_m0_req_addr", req_addr, 32'h204);
        cyc();
        m0_req_valid = 0; req_ready = 0;
        resp_valid = 1; resp_rdata = 32'h1111_1111; m0_resp_ready = 1; m1_resp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d_m1_resp_valid", k), m1_resp_valid, 1);
            check($sformatf("bp%0d_m0_resp_valid", k), m0_resp_valid, 0);
            check($sformatf("bp%0d_resp_ready", k), resp_ready, 0);
            check($sformatf("bp%0d_outstanding", k), outstanding, 2);
            cyc();
        end
        m1_resp_ready = 1;
        #1;
        check("bp_m1_rdata", m1_resp_rdata, 32'h1111_1111);
        check("bp_m1_accept", resp_ready, 1);
        cyc();
        resp_rdata = 32'h2222_2222; resp_error = 1;
        #1;
        check("bp_m0_resp_valid", m0_resp_valid, 1);
        check("bp_m1_resp_idle", m1_resp_valid, 0);
        check("bp_m0_rdata", m0_resp_rdata, 32'h2222_2222);
        check("bp_m0_error", m0_resp_error, 1);
        cyc();
        idle();
        #1;
        check("bp_outstanding", outstanding, 0);

        // reset mid-operation, then a stale response is spurious
        cyc();
        m0_req_valid = 1; req_ready = 1;
        cyc();
        idle();
        #1;
        check("mid_outstanding", outstanding, 1);
        cyc();
        rst_n = 0;
        #1;
        check("mid_rst_outstanding", outstanding, 0);
        check("mid_rst_resp_ready", resp_ready, 1);
        cyc();
        rst_n = 1;
        resp_valid = 1; resp_rdata = 32'h3333_3333;
        #1;
        check("sp_resp_ready", resp_ready, 1);
        check("sp_m0_resp_valid", m0_resp_valid, 0);
        check("sp_m1_resp_valid", m1_resp_valid, 0);
        check("sp_before_edge", spurious_resp, 0);
        cyc();
        resp_valid = 0;
        #1;
        check("sp_set", spurious_resp, 1);
        check("sp_no_underflow", outstanding, 0);
        cyc();
        m0_req_valid = 1; m1_req_valid = 1; req_ready = 1;
        m0_req_addr = A0; m1_req_addr = A1;
        #1;
        check("sp_held", spurious_resp, 1);
        check("rst_rr_m0_first", m0_req_ready, 1);
        check("rst_rr_addr", req_addr, A0);
        cyc();
        idle();
        rst_n = 0;
        #1;
        check("sp_cleared", spurious_resp, 0);
        cyc();
        rst_n = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ls_req_arbiter.md
# ls_req_arbiter

Two-master request arbiter that sits directly upstream of `load_store_top`. It merges two independent load/store requesters (m0, m1) onto the single valid/ready request port. It records which master issued each accepted request, then routes every in-order response from `load_store_top` back to the master that issued it. Arbitration is round-robin and outstanding requests are bounded, so a stalled response path never loses ordering information.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: request address width.
- `DATA_WIDTH`, default 32: write and read data width.
- `MAX_OUTSTANDING`, default 4: depth of the order FIFO. Power of two, 2..16.

Ports (N = 0, 1; one master port set per N):
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mN_req_valid`  in  1  master N has a request.
- `mN_req_ready`  out  1  master N request accepted this cycle.
- `mN_req_wr`  in  1  1 = store, 0 = load.
- `mN_req_addr`  in  ADDR_WIDTH  byte address.
- `mN_req_wdata`  in  DATA_WIDTH  store data.
- `mN_resp_valid`  out  1  response for master N.
- `mN_resp_ready`  in  1  master N accepts the response.
- `mN_resp_rdata`  out  DATA_WIDTH  load data.
- `mN_resp_error`  out  1  error flag.
- `req_valid` / `req_ready` / `req_wr` / `req_addr` / `req_wdata`  out/in/out/out/out  1/1/1/ADDR_WIDTH/DATA_WIDTH  downstream request to `load_store_top`.
- `resp_valid` / `resp_ready` / `resp_rdata` / `resp_error`  in/out/in/in  1/1/DATA_WIDTH/1  downstream response from `load_store_top`.
- `outstanding`  out  $clog2(MAX_OUTSTANDING)+1  current order-FIFO occupancy.
- `spurious_resp`  out  1  sticky: a response arrived with no outstanding request.

## Operation

- State:
  - `rr_ptr`: master that has priority; reset 0.
  - `lock`, `lock_id`: grant held; reset 0.
  - Order FIFO of 1-bit master IDs, plus count; reset empty.
  - `spurious_resp`: reset 0.
- Grant selection:
  - If `lock` is set, grant = `lock_id`.
  - Otherwise, the requesting master equal to `rr_ptr` wins; if only one master requests, it wins.
- Downstream request:
  - `req_valid` = granted master's valid AND order FIFO not full.
  - Payload is muxed from the granted master.
  - `mN_req_ready` = (grant==N) AND `req_ready` AND FIFO not full.
- Lock:
  - `lock` is set when `req_valid` is high and `req_ready` is low.
  - It is cleared on the downstream handshake.
  - This keeps the payload stable until acceptance; a competing master cannot pre-empt a presented request.
- Downstream request handshake: push the grant ID into the order FIFO; `rr_ptr` becomes the other master.
- Response path:
  - FIFO non-empty: with head ID = H, `mH_resp_valid` = `resp_valid`, `resp_ready` = `mH_resp_ready`, data and error are forwarded. The other master's `resp_valid` = 0. The FIFO pops on the `resp_valid && resp_ready` handshake.
  - FIFO empty: `resp_ready` = 1 and the response is dropped. `spurious_resp` sets and holds until reset.
- Simultaneous push and pop: count unchanged. Pop in the same cycle does not free a slot for that cycle's push; full is evaluated on the registered count.
- Reset mid-operation: FIFO cleared, lock cleared, `rr_ptr` = 0. Responses for pre-reset requests then count as spurious.

## Timing

- Request and response paths are combinational pass-through: zero added cycles. The accept cycle equals the downstream accept cycle.
- Outputs during reset and immediately after:
  - All `*_valid` and `*_ready` outputs = 0, except `resp_ready` = 1 (FIFO empty).
  - `outstanding` = 0, `spurious_resp` = 0.
  - Data outputs follow the mux; their value is unspecified while the corresponding valid is 0.
- Back-to-back requests from both masters alternate m0, m1, m0, … one per cycle when `req_ready` = 1.
- With `MAX_OUTSTANDING` requests outstanding, requests stall until at least one response handshake has completed in an earlier cycle.

## Configuration

- `LS_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority; m0 always wins when both masters request and no lock is held. `rr_ptr` is removed.
  - Undefined (default): round-robin as described above.
- Locking, order tracking and response routing are identical in both modes.

## Test plan

- m0 store 0x100 ← 0xDEADBEEF, then m1 load 0x100 → m1 receives 0xDEADBEEF with error 0; m0 receives exactly one write response.
- m0 and m1 both hold valid for 4 cycles with `req_ready` = 1 → grant order m0, m1, m0, m1; `outstanding` peaks at 4 with `resp_ready` held low by both masters.
- `req_ready` held low for 3 cycles while m0 is presented and m1 asserts in cycle 2 → m0 payload stays stable; m0 is accepted first.
- 5 requests with no responses returned (`MAX_OUTSTANDING` = 4) → the 5th stalls, with `mN_req_ready` = 0, until the first response handshake.
- m1 load 0x200 = 0x11111111 then m0 load 0x204 = 0x22222222, with m1 holding `resp_ready` = 0 for 3 cycles → m0 receives no response until m1 accepts; data is routed correctly.
- `resp_valid` pulse while the FIFO is empty → `resp_ready` = 1, no master response, `spurious_resp` = 1 until `rst_n` goes low.
